// File: rtl/mshr_controller_pkg.sv
// Shared types for the data-cache MSHR controller: entry state, memory command
// encoding and the fill broadcast packet seen by the load buffer.
package mshr_controller_pkg;

  // Packet index field is sized for the largest supported MSHR count; narrower
  // configurations zero-extend into it.
  localparam int MSHR_IDX_MAX_W = 8;

  typedef logic [MSHR_IDX_MAX_W-1:0] MSHR_IDX;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'd0,
    MEM_LOAD  = 2'd1,
    MEM_STORE = 2'd2
  } MEM_COMMAND;

  typedef enum logic [1:0] {
    FREE    = 2'd0,
    PENDING = 2'd1,
    WAITING = 2'd2,
    FILL    = 2'd3
  } MSHR_STATE;

  typedef struct packed {
    MSHR_STATE   state;
    logic [28:0] line;
    logic [3:0]  tag;
  } MSHR_ENTRY;

  typedef struct packed {
    logic        valid;
    MSHR_IDX     mshr_idx;
    logic [63:0] data;
  } LOAD_BUFFER_CACHE_PACKET;

  localparam LOAD_BUFFER_CACHE_PACKET NOP_LOAD_BUFFER_CACHE_PACKET = '0;

endpackage

// File: rtl/mshr_controller_issue_fifo.sv
// Circular FIFO of MSHR indices holding allocation order; only the head may
// issue to memory. Depth must be a power of two so the pointers wrap freely.
module mshr_issue_fifo #(
  parameter int DEPTH = 4,
  parameter int IDX_W = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_i,
  input  logic [IDX_W-1:0] push_data_i,
  input  logic             pop_i,
  output logic [IDX_W-1:0] head_o,
  output logic             empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [IDX_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && (count_q != (PTR_W+1)'(DEPTH));

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = count_q + {{PTR_W{1'b0}}, do_push} - {{PTR_W{1'b0}}, do_pop};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/mshr_controller.sv
// MSHR controller: allocates entries for line misses, issues MEM_LOADs in
// allocation order and broadcasts fills. Define MSHR_MERGE_EN to merge same-line misses.
module mshr_controller
  import mshr_controller_pkg::*;
#(
  parameter int MSHR_SZ    = 4,
  parameter int MSHR_IDX_W = $clog2(MSHR_SZ)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    miss_req_valid,
  input  logic [31:0]             miss_req_addr,
  output logic                    miss_req_ready,
  output logic [MSHR_IDX_W-1:0]   miss_mshr_idx,
  output logic                    mem_port_req,
  input  logic                    mem_port_gnt,
  output MEM_COMMAND              proc2mem_command,
  output logic [31:0]             proc2mem_addr,
  input  logic [3:0]              mem2proc_transaction_tag,
  input  logic [3:0]              mem2proc_data_tag,
  input  logic [63:0]             mem2proc_data,
  output LOAD_BUFFER_CACHE_PACKET load_buffer_cache_packet,
  output logic [31:0]             fill_addr,
  output logic                    mshr_busy
);

  MSHR_ENTRY               entry_q [MSHR_SZ];
  MSHR_ENTRY               entry_d [MSHR_SZ];
  LOAD_BUFFER_CACHE_PACKET packet_q, packet_d;
  logic [31:0]             fill_addr_q, fill_addr_d;

  logic [28:0]             req_line;
  logic                    addr_offset_unused;
  logic [MSHR_SZ-1:0]      free_vec, merge_vec, fill_vec;
  logic [MSHR_IDX_W-1:0]   alloc_idx, merge_idx, fill_idx, head_idx;
  logic                    free_any, merge_hit, fill_hit;
  logic                    alloc, issue, issue_ok, fifo_empty;

  assign req_line           = miss_req_addr[31:3];
  assign addr_offset_unused = ^miss_req_addr[2:0];

  genvar gi;
  generate
    for (gi = 0; gi < MSHR_SZ; gi++) begin : g_entry
      assign free_vec[gi] = (entry_q[gi].state == FREE);
      assign fill_vec[gi] = (entry_q[gi].state == WAITING) &&
                            (mem2proc_data_tag != 4'd0) &&
                            (entry_q[gi].tag == mem2proc_data_tag);
`ifdef MSHR_MERGE_EN
      // FILL entries are about to be freed, so they never absorb a new miss.
      assign merge_vec[gi] = ((entry_q[gi].state == PENDING) ||
                              (entry_q[gi].state == WAITING)) &&
                             (entry_q[gi].line == req_line);
`else
      assign merge_vec[gi] = 1'b0;
`endif
    end
  endgenerate

  // Lowest-index priority encoders for allocation, merge target and fill match.
  always_comb begin
    alloc_idx = '0;
    merge_idx = '0;
    fill_idx  = '0;
    for (int i = MSHR_SZ - 1; i >= 0; i--) begin
      if (free_vec[i])  alloc_idx = MSHR_IDX_W'(i);
      if (merge_vec[i]) merge_idx = MSHR_IDX_W'(i);
      if (fill_vec[i])  fill_idx  = MSHR_IDX_W'(i);
    end
  end

  assign free_any  = |free_vec;
  assign merge_hit = |merge_vec;
  assign fill_hit  = |fill_vec;

  assign miss_req_ready = miss_req_valid && (free_any || merge_hit);
  assign miss_mshr_idx  = merge_hit ? merge_idx : alloc_idx;
  assign alloc          = miss_req_valid && free_any && !merge_hit;

  mshr_issue_fifo #(
    .DEPTH (MSHR_SZ),
    .IDX_W (MSHR_IDX_W)
  ) u_issue_fifo (
    .clock       (clock),
    .reset       (reset),
    .push_i      (alloc),
    .push_data_i (alloc_idx),
    .pop_i       (issue_ok),
    .head_o      (head_idx),
    .empty_o     (fifo_empty)
  );

  assign mem_port_req     = !fifo_empty;
  assign issue            = mem_port_req && mem_port_gnt;
  assign issue_ok         = issue && (mem2proc_transaction_tag != 4'd0);
  assign proc2mem_command = issue ? MEM_LOAD : MEM_NONE;
  assign proc2mem_addr    = issue ? {entry_q[head_idx].line, 3'b000} : 32'd0;

  always_comb begin
    for (int i = 0; i < MSHR_SZ; i++) begin
      entry_d[i] = entry_q[i];
      case (entry_q[i].state)
        FREE: begin
          if (alloc && (alloc_idx == MSHR_IDX_W'(i))) begin
            entry_d[i].state = PENDING;
            entry_d[i].line  = req_line;
            entry_d[i].tag   = 4'd0;
          end
        end
        PENDING: begin
          if (issue_ok && (head_idx == MSHR_IDX_W'(i))) begin
            entry_d[i].state = WAITING;
            entry_d[i].tag   = mem2proc_transaction_tag;
          end
        end
        WAITING: begin
          if (fill_hit && (fill_idx == MSHR_IDX_W'(i))) entry_d[i].state = FILL;
        end
        FILL: entry_d[i].state = FREE;
      endcase
    end
  end

  always_comb begin
    packet_d    = NOP_LOAD_BUFFER_CACHE_PACKET;
    fill_addr_d = 32'd0;
    if (fill_hit) begin
      packet_d.valid    = 1'b1;
      packet_d.mshr_idx = MSHR_IDX'(fill_idx);
      packet_d.data     = mem2proc_data;
      fill_addr_d       = {entry_q[fill_idx].line, 3'b000};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < MSHR_SZ; i++) entry_q[i] <= '0;
      packet_q    <= NOP_LOAD_BUFFER_CACHE_PACKET;
      fill_addr_q <= 32'd0;
    end else begin
      entry_q     <= entry_d;
      packet_q    <= packet_d;
      fill_addr_q <= fill_addr_d;
    end
  end

  assign load_buffer_cache_packet = packet_q;
  assign fill_addr                = fill_addr_q;
  assign mshr_busy                = ~&free_vec;

endmodule
